bnn_mem_buffer: RTL and testbench



---
 rtl/bnn_mem_buffer_pkg.sv | 20 ++
 rtl/bnn_mem_buffer_slot.sv | 41 ++++
 rtl/bnn_mem_buffer.sv | 84 ++++++++
 tb/tb_bnn_mem_buffer.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/bnn_mem_buffer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : bnn_mem_buffer_pkg
//  Description : Shared defaults and helpers for the BNN sample buffer.
//                Exports the default sample width and buffer depth, plus a
//                saturating increment used by the fill counter.
//  Revision    : 1.0 - initial release
// ============================================================================
package bnn_mem_buffer_pkg;

  localparam int BNN_DEFAULT_WIDTH  = 5;
  localparam int BNN_DEFAULT_LENGTH = 5;

  // Increment that stops at the limit instead of wrapping.
  function automatic int sat_inc(input int value, input int limit);
    return (value >= limit) ? limit : value + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/bnn_mem_buffer_slot.sv
`default_nettype none
// ============================================================================
//  Module      : bnn_mem_buffer_slot
//  Description : One width-bit storage slot of the sample buffer. Loads d on
//                an enabled edge, holds otherwise, clears on rst.
//  Ports       : clk, rst (sync, active-high), en (load enable),
//                d (next sample), q (stored sample, registered)
//  Revision    : 1.0 - initial release
// ============================================================================
module bnn_mem_buffer_slot #(
  parameter int width = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [width-1:0] d,
  output logic [width-1:0] q
);

  logic [width-1:0] q_d;
  logic [width-1:0] q_q;

  always_comb begin
    q_d = q_q;
    if (en) begin
      q_d = d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule
`default_nettype wire

// File: rtl/bnn_mem_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : bnn_mem_buffer
//  Description : Shift-register sample buffer holding the last `length`
//                samples of `width` bits. Slot 0 is the newest sample; all
//                slots are presented as one flat word. A saturating counter
//                tracks how many valid samples are held.
//  Ports       : clk, rst (sync, active-high), en (shift enable),
//                data_in [width], data_out [width*length] (slot k at
//                [k*width +: width]), count [$clog2(length+1)], full
//  Revision    : 1.0 - initial release
// ============================================================================
module bnn_mem_buffer
  import bnn_mem_buffer_pkg::*;
#(
  parameter int width  = BNN_DEFAULT_WIDTH,
  parameter int length = BNN_DEFAULT_LENGTH
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         en,
  input  logic [width-1:0]             data_in,
  output logic [width*length-1:0]      data_out,
  output logic [$clog2(length+1)-1:0]  count,
  output logic                         full
);

  localparam int                  c_count_w   = $clog2(length + 1);
  localparam logic [c_count_w-1:0] c_count_max = c_count_w'(length);

  logic [width-1:0]     slot_q [length];
  logic [c_count_w-1:0] count_d;
  logic [c_count_w-1:0] count_q;
  logic                 full_d;
  logic                 full_q;

  // Slot chain: slot 0 takes the new sample, every other slot takes its
  // predecessor. All slots share the enable so the chain shifts as a unit.
  for (genvar k = 0; k < length; k++) begin : g_slot
    logic [width-1:0] slot_d;

    if (k == 0) begin : g_head
      assign slot_d = data_in;
    end else begin : g_tail
      assign slot_d = slot_q[k-1];
    end

    bnn_mem_buffer_slot #(
      .width (width)
    ) u_slot (
      .clk (clk),
      .rst (rst),
      .en  (en),
      .d   (slot_d),
      .q   (slot_q[k])
    );

    assign data_out[k*width +: width] = slot_q[k];
  end

  always_comb begin
    count_d = count_q;
    if (en) begin
      count_d = c_count_w'(sat_inc(int'(count_q), length));
    end
    // The counter saturates, so full is sticky until reset.
    full_d = (count_d == c_count_max);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
      full_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      full_q  <= full_d;
    end
  end

  assign count = count_q;
  assign full  = full_q;

endmodule
`default_nettype wire

// File: tb/tb_bnn_mem_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bnn_mem_buffer
//  Description : Self-checking bench for bnn_mem_buffer. Three instances
//                (5x5, 1x1, 8x16) share clock, reset and enable; each sees
//                the low bits of a common sample. A history queue of accepted
//                samples is the reference for all three.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bnn_mem_buffer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b0;
  logic       en  = 1'b0;
  logic [7:0] din = 8'd0;

  logic [24:0]  data_a;
  logic [2:0]   count_a;
  logic         full_a;
  logic [0:0]   data_b;
  logic [0:0]   count_b;
  logic         full_b;
  logic [127:0] data_c;
  logic [4:0]   count_c;
  logic         full_c;

  bnn_mem_buffer #(.width(5), .length(5)) u_dut_a (
    .clk(clk), .rst(rst), .en(en), .data_in(din[4:0]),
    .data_out(data_a), .count(count_a), .full(full_a)
  );

  bnn_mem_buffer #(.width(1), .length(1)) u_dut_b (
    .clk(clk), .rst(rst), .en(en), .data_in(din[0:0]),
    .data_out(data_b), .count(count_b), .full(full_b)
  );

  bnn_mem_buffer #(.width(8), .length(16)) u_dut_c (
    .clk(clk), .rst(rst), .en(en), .data_in(din),
    .data_out(data_c), .count(count_c), .full(full_c)
  );

  // Reference: most recent accepted sample first, accepts since reset.
  int hist[$];
  int n_acc = 0;

  int vectors    = 0;
  int miscompares = 0;

  function automatic logic [127:0] exp_data(input int w, input int l);
    logic [127:0] r;
    r = '0;
    for (int k = 0; k < l; k++) begin
      if (k < hist.size()) begin
        r = r | (128'(hist[k] & ((1 << w) - 1)) << (k * w));
      end
    end
    return r;
  endfunction

  function automatic int exp_count(input int l);
    return (n_acc < l) ? n_acc : l;
  endfunction

  task automatic cmp(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    cmp({tag, ".a.data"},  128'(data_a),  exp_data(5, 5));
    cmp({tag, ".a.count"}, 128'(count_a), 128'(exp_count(5)));
    cmp({tag, ".a.full"},  128'(full_a),  128'(exp_count(5) == 5));
    cmp({tag, ".b.data"},  128'(data_b),  exp_data(1, 1));
    cmp({tag, ".b.count"}, 128'(count_b), 128'(exp_count(1)));
    cmp({tag, ".b.full"},  128'(full_b),  128'(exp_count(1) == 1));
    cmp({tag, ".c.data"},  data_c,        exp_data(8, 16));
    cmp({tag, ".c.count"}, 128'(count_c), 128'(exp_count(16)));
    cmp({tag, ".c.full"},  128'(full_c),  128'(exp_count(16) == 16));
  endtask

  // One clock: drive on the falling edge, update the model at the rising
  // edge, then check shortly after it.
  task automatic step(input logic s_rst, input logic s_en, input int s_din, input string tag);
    @(negedge clk);
    rst = s_rst;
    en  = s_en;
    din = 8'(s_din);
    @(posedge clk);
    if (s_rst) begin
      hist.delete();
      n_acc = 0;
    end else if (s_en) begin
      hist.push_front(s_din & 8'hFF);
      if (hist.size() > 16) void'(hist.pop_back());
      n_acc++;
    end
    #1;
    check_all(tag);
  endtask

  initial begin
    logic [24:0] a_exp;

    // Reset state.
    step(1'b1, 1'b0, 0, "reset");
    cmp("reset.a.zero", 128'(data_a), 128'd0);

    // Basic fill.
    step(1'b0, 1'b1, 10, "fill");
    step(1'b0, 1'b1, 12, "fill");
    step(1'b0, 1'b1, 3,  "fill");
    cmp("fill.a.flat",  128'(data_a),  128'd10627);
    cmp("fill.a.count", 128'(count_a), 128'd3);
    cmp("fill.a.full",  128'(full_a),  128'd0);

    // Overflow: full first rises after the fifth accept.
    step(1'b1, 1'b0, 0, "reset");
    for (int i = 1; i <= 7; i++) begin
      step(1'b0, 1'b1, i, "ovf");
      if (i == 4) cmp("ovf.a.full_before", 128'(full_a), 128'd0);
      if (i == 5) cmp("ovf.a.full_rise",   128'(full_a), 128'd1);
    end
    a_exp = {5'd3, 5'd4, 5'd5, 5'd6, 5'd7};
    cmp("ovf.a.flat",  128'(data_a),  128'(a_exp));
    cmp("ovf.a.count", 128'(count_a), 128'd5);

    // Reset mid-stream wins over enable; sample 21 is dropped.
    step(1'b1, 1'b1, 21, "midrst");
    cmp("midrst.a.flat", 128'(data_a), 128'd0);
    cmp("midrst.a.full", 128'(full_a), 128'd0);
    step(1'b0, 1'b1, 4, "restart");
    cmp("restart.a.flat", 128'(data_a), 128'd4);

    // Enable gating.
    step(1'b1, 1'b0, 0, "reset");
    step(1'b0, 1'b1, 9, "gate");
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b0, 30, "gap");
      cmp("gap.a.flat", 128'(data_a), 128'd9);
    end
    step(1'b0, 1'b1, 17, "gate");
    a_exp = {15'd0, 5'd9, 5'd17};
    cmp("gate.a.flat",  128'(data_a),  128'(a_exp));
    cmp("gate.a.count", 128'(count_a), 128'd2);
    // 1x1 instance follows the last accepted bit (17 -> 1) and is full.
    cmp("gate.b.data", 128'(data_b), 128'd1);
    cmp("gate.b.full", 128'(full_b), 128'd1);

    // Deep instance: 16 accepts of 0..15 leave slot k = 15-k.
    step(1'b1, 1'b0, 0, "reset");
    for (int i = 0; i < 16; i++) step(1'b0, 1'b1, i, "deep");
    for (int k = 0; k < 16; k++) begin
      cmp("deep.c.slot", 128'(data_c[k*8 +: 8]), 128'(15 - k));
    end
    cmp("deep.c.full", 128'(full_c), 128'd1);

    // Randomised traffic with occasional resets.
    for (int i = 0; i < 60; i++) begin
      step(($urandom_range(0, 19) == 0), $urandom_range(0, 1) == 1,
           int'($urandom_range(0, 255)), "rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
